// File: rtl/adder_pkg.sv
// Shared defaults and helpers for the carry-lookahead adder.
package adder_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int GRP_DEF   = 4;

    // Signed overflow: both operands share a sign that the result does not.
    function automatic logic of_calc(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb & b_msb & ~s_msb) | (~a_msb & ~b_msb & s_msb);
    endfunction

endpackage

// File: rtl/adder_cla_group.sv
// One lookahead group: GRP sum bits plus the group propagate/generate
// terms consumed by the second-level lookahead in the top level.
module cla_group #(
    parameter int GRP = 4
) (
    input  logic [GRP-1:0] a,
    input  logic [GRP-1:0] b,
    input  logic           cin,
    output logic [GRP-1:0] sum,
    output logic           p_grp,
    output logic           g_grp
);

    logic [GRP-1:0] p;
    logic [GRP-1:0] g;
    logic [GRP-1:0] c;

    assign p = a ^ b;
    assign g = a & b;

    always_comb begin
        c[0] = cin;
        for (int i = 1; i < GRP; i++) begin
            c[i] = g[i-1] | (p[i-1] & c[i-1]);
        end
    end

    assign sum = p ^ c;

    // Group terms are independent of cin so the top-level lookahead has no loop.
    always_comb begin
        logic g_acc;
        g_acc = 1'b0;
        for (int i = 0; i < GRP; i++) begin
            g_acc = g[i] | (p[i] & g_acc);
        end
        g_grp = g_acc;
        p_grp = &p;
    end

endmodule

// File: rtl/adder.sv
// Two-level carry-lookahead adder with combinational results and a
// one-cycle registered copy for pipelined consumers.
module adder
    import adder_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int GRP   = GRP_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             co,
    output logic             OF,
    output logic [WIDTH-1:0] sum_q,
    output logic             co_q,
    output logic             OF_q
);

    localparam int NGRP = WIDTH / GRP;

    logic [NGRP-1:0] grp_p;
    logic [NGRP-1:0] grp_g;
    logic [NGRP:0]   grp_c;

    logic [WIDTH-1:0] sum_d;
    logic             co_d;
    logic             OF_d;

    for (genvar k = 0; k < NGRP; k++) begin : g_grp
        cla_group #(
            .GRP(GRP)
        ) u_grp (
            .a    (a[k*GRP +: GRP]),
            .b    (b[k*GRP +: GRP]),
            .cin  (grp_c[k]),
            .sum  (sum[k*GRP +: GRP]),
            .p_grp(grp_p[k]),
            .g_grp(grp_g[k])
        );
    end

    always_comb begin
        grp_c[0] = cin;
        for (int k = 0; k < NGRP; k++) begin
            grp_c[k+1] = grp_g[k] | (grp_p[k] & grp_c[k]);
        end
    end

    assign co = grp_c[NGRP];
    assign OF = of_calc(a[WIDTH-1], b[WIDTH-1], sum[WIDTH-1]);

    always_comb begin
        sum_d = sum;
        co_d  = co;
        OF_d  = OF;
    end

    // Reset clears only the pipeline copy; the combinational path keeps tracking inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q <= '0;
            co_q  <= 1'b0;
            OF_q  <= 1'b0;
        end else begin
            sum_q <= sum_d;
            co_q  <= co_d;
            OF_q  <= OF_d;
        end
    end

endmodule

// File: tb/tb_adder.sv
// Randomised scoreboard bench for the lookahead adder: combinational results
// are checked right after each drive, registered results by a separate monitor.
module tb_adder;

   localparam int W = 32;

   typedef struct packed {
      logic [W-1:0] s;
      logic         c;
      logic         o;
   } res_t;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [W-1:0] a   = '0;
   logic [W-1:0] b   = '0;
   logic         cin = 1'b0;
   logic [W-1:0] sum;
   logic         co;
   logic         OF;
   logic [W-1:0] sum_q;
   logic         co_q;
   logic         OF_q;

   res_t expQ[$];
   res_t monExp;
   int   numVectors     = 0;
   int   numMiscompares = 0;

   adder dut (
      .clk  (clk),
      .rst  (rst),
      .a    (a),
      .b    (b),
      .cin  (cin),
      .sum  (sum),
      .co   (co),
      .OF   (OF),
      .sum_q(sum_q),
      .co_q (co_q),
      .OF_q (OF_q)
   );

   // Free-running clock, period 10.
   always #5 clk = ~clk;

   // Reference: unsigned 33-bit sum for sum/carry, signed 64-bit range test for overflow.
   function automatic res_t refModel(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
      res_t         r;
      logic [W:0]   u;
      longint       full;
      longint       maxS;
      longint       minS;
      u    = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
      full = longint'($signed(x)) + longint'($signed(y)) + longint'(ci);
      maxS = (64'sd1 <<< (W - 1)) - 64'sd1;
      minS = -(64'sd1 <<< (W - 1));
      r.s  = u[W-1:0];
      r.c  = u[W];
      r.o  = (full > maxS) || (full < minS);
      return r;
   endfunction

   // Compare one observed result triple against its expectation.
   task automatic checkOutput(input string name, input res_t act, input res_t exp);
      numVectors++;
      if (act !== exp) begin
         numMiscompares++;
         $display("[TB] FAIL %s: got sum=%h co=%b OF=%b, expected sum=%h co=%b OF=%b",
                  name, act.s, act.c, act.o, exp.s, exp.c, exp.o);
      end
   endtask

   // Drive one vector on the falling edge, check the combinational path, queue the registered expectation.
   task automatic applyStimulus(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci, input logic r);
      res_t e;
      @(negedge clk);
      a   = x;
      b   = y;
      cin = ci;
      rst = r;
      #1;
      e = refModel(x, y, ci);
      checkOutput("comb", {sum, co, OF}, e);
      expQ.push_back(r ? res_t'('0) : e);
   endtask

   // Monitor: each rising edge consumes one queued expectation for the registered outputs.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (expQ.size() > 0) begin
            monExp = expQ.pop_front();
            checkOutput("reg", {sum_q, co_q, OF_q}, monExp);
         end
      end
   end

   // Directed corner vectors followed by the reset sequence and random traffic.
   initial begin
      logic [W-1:0] dirA [5];
      logic [W-1:0] dirB [5];
      logic         dirC [5];
      logic [W-1:0] ra;
      logic [W-1:0] rb;

      dirA = '{32'h0000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
      dirB = '{32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h8000_0000, 32'h0000_0000};
      dirC = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

      applyStimulus(32'h1234_5678, 32'h0F0F_0F0F, 1'b1, 1'b1);

      for (int i = 0; i < 5; i++) begin
         applyStimulus(dirA[i], dirB[i], dirC[i], 1'b0);
      end

      applyStimulus(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b1);
      applyStimulus(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0);

      for (int i = 0; i < 60; i++) begin
         ra = $urandom();
         rb = $urandom();
         if (i % 8 == 3) rb = ~ra;
         if (i % 8 == 5) ra = {1'b0, {(W-1){1'b1}}};
         applyStimulus(ra, rb, 1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0));
      end

      for (int i = 0; i < 5 && expQ.size() > 0; i++) begin
         @(negedge clk);
      end
      if (expQ.size() > 0) begin
         numVectors++;
         numMiscompares++;
         $display("[TB] FAIL drain: %0d registered results outstanding, expected 0", expQ.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", numVectors, numMiscompares);
      $finish;
   end

endmodule
